// File: rtl/ctrl_pkg.sv
// Shared definitions for the RISC control unit and instruction decoder:
// opcode map, ALU op encodings, sequencer states and instruction classes.
package ctrl_pkg;

    localparam logic [2:0] OP_LOGIC  = 3'b000;
    localparam logic [2:0] OP_BLT    = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_ADDSUB = 3'b011;
    localparam logic [2:0] OP_SHIFT  = 3'b100;
    localparam logic [2:0] OP_BEQ    = 3'b101;
    localparam logic [2:0] OP_STORE  = 3'b110;
    localparam logic [2:0] OP_JMP    = 3'b111;

    localparam logic [1:0] ALU_LOGIC  = 2'b00;
    localparam logic [1:0] ALU_ADDSUB = 2'b01;
    localparam logic [1:0] ALU_SHIFT  = 2'b10;
    localparam logic [1:0] ALU_CMP    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } ctrl_state_t;

    typedef enum logic [3:0] {
        CLS_LOGIC,
        CLS_ADDSUB,
        CLS_SHIFT,
        CLS_BLT,
        CLS_BEQ,
        CLS_LOAD,
        CLS_STORE,
        CLS_JMP,
        CLS_ILLEGAL
    } instr_class_t;

    // Opcode 111 doubles as JMP (fn=1) and the illegal encoding (fn=0).
    function automatic instr_class_t decode_class(input logic [2:0] op, input logic fn);
        instr_class_t cls;
        case (op)
            OP_LOGIC:  cls = CLS_LOGIC;
            OP_BLT:    cls = CLS_BLT;
            OP_LOAD:   cls = CLS_LOAD;
            OP_ADDSUB: cls = CLS_ADDSUB;
            OP_SHIFT:  cls = CLS_SHIFT;
            OP_BEQ:    cls = CLS_BEQ;
            OP_STORE:  cls = CLS_STORE;
            OP_JMP:    cls = fn ? CLS_JMP : CLS_ILLEGAL;
            default:   cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic [1:0] class_alu_op(input instr_class_t cls);
        logic [1:0] op;
        case (cls)
            CLS_ADDSUB: op = ALU_ADDSUB;
            CLS_SHIFT:  op = ALU_SHIFT;
            default:    op = ALU_LOGIC;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 8-bit RISC core (fetch/decode/exec/mem/wb).
// Optional build macro CTRL_HALT_ON_ILLEGAL_EN: illegal opcodes halt instead of acting as NOP.
module control_unit
    import ctrl_pkg::*;
#(
    parameter bit RUN_ON_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] opcode,
    input  logic       fn,
    input  logic       alu_lt,
    input  logic       alu_eq,
    input  logic       mem_ack,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       rf_we,
    output logic       wb_sel,
    output logic [1:0] alu_op,
    output logic       alu_fn,
    output logic       mem_req,
    output logic       mem_we,
    output logic       busy,
    output logic       halted
);

    localparam ctrl_state_t RESET_STATE = RUN_ON_RESET ? ST_FETCH : ST_IDLE;

    ctrl_state_t  state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic         fn_q, fn_d;
    instr_class_t cls;
    ctrl_state_t  boundary_state;
    logic         alu_class;

    assign cls            = decode_class(op_q, fn_q);
    assign alu_class      = (cls == CLS_LOGIC) || (cls == CLS_ADDSUB) || (cls == CLS_SHIFT);
    assign boundary_state = run ? ST_FETCH : ST_IDLE;

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            op_q    <= OP_LOGIC;
            fn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
        end
    end

    // NOTE: every always_comb target is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fn_d    = fn_q;
        unique case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                op_d    = opcode;
                fn_d    = fn;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (alu_class) begin
                    state_d = ST_WB;
                end else if ((cls == CLS_LOAD) || (cls == CLS_STORE)) begin
                    state_d = ST_MEM;
                end else if (cls == CLS_ILLEGAL) begin
`ifdef CTRL_HALT_ON_ILLEGAL_EN
                    state_d = ST_HALT;
`else
                    state_d = boundary_state;
`endif
                end else begin
                    state_d = boundary_state;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    if (cls == CLS_LOAD) state_d = ST_WB;
                    else                 state_d = boundary_state;
                end
            end
            ST_WB:   state_d = boundary_state;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        rf_we   = 1'b0;
        wb_sel  = 1'b0;
        alu_op  = ALU_LOGIC;
        alu_fn  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ST_FETCH: ir_load = 1'b1;
            ST_EXEC: begin
                case (cls)
                    CLS_LOGIC, CLS_ADDSUB, CLS_SHIFT: begin
                        alu_op = class_alu_op(cls);
                        alu_fn = fn_q;
                    end
                    CLS_BLT, CLS_BEQ: begin
                        alu_op = ALU_CMP;
                        alu_fn = 1'b1;
                        if ((cls == CLS_BLT) ? alu_lt : alu_eq) pc_load = 1'b1;
                        else                                    pc_inc  = 1'b1;
                    end
                    CLS_JMP: pc_load = 1'b1;
                    CLS_ILLEGAL: begin
`ifdef CTRL_HALT_ON_ILLEGAL_EN
                        pc_inc = 1'b0;
`else
                        pc_inc = 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls == CLS_STORE);
                pc_inc  = (cls == CLS_STORE) && mem_ack;
            end
            ST_WB: begin
                rf_we  = 1'b1;
                wb_sel = (cls == CLS_LOAD);
                pc_inc = 1'b1;
                if (alu_class) begin
                    alu_op = class_alu_op(cls);
                    alu_fn = fn_q;
                end
            end
            default: ;
        endcase

        busy = (state_q != ST_IDLE) && (state_q != ST_HALT);
`ifdef CTRL_HALT_ON_ILLEGAL_EN
        halted = (state_q == ST_HALT);
`else
        halted = 1'b0;
`endif

        // Reset silences every strobe immediately, even in the RUN_ON_RESET FETCH state.
        if (rst) begin
            ir_load = 1'b0;
            pc_inc  = 1'b0;
            pc_load = 1'b0;
            rf_we   = 1'b0;
            wb_sel  = 1'b0;
            alu_op  = ALU_LOGIC;
            alu_fn  = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
            busy    = 1'b0;
            halted  = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed steps plus random instruction
// streams checked cycle by cycle against an instruction-level reference model.
`timescale 1ns/1ps
module tb_control_unit;

    typedef struct packed {
        logic       ir_load;
        logic       pc_inc;
        logic       pc_load;
        logic       rf_we;
        logic       wb_sel;
        logic [1:0] alu_op;
        logic       alu_fn;
        logic       mem_req;
        logic       mem_we;
        logic       busy;
        logic       halted;
    } out_t;

    logic       clk = 1'b0;
    logic       rst, run, fn, alu_lt, alu_eq, mem_ack;
    logic [2:0] opcode;
    logic       ir_load, pc_inc, pc_load, rf_we, wb_sel, alu_fn, mem_req, mem_we, busy, halted;
    logic [1:0] alu_op;
    out_t       obs;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt, strobe_cnt, first_strobe;
    bit next_fetch;

    assign obs = {ir_load, pc_inc, pc_load, rf_we, wb_sel, alu_op, alu_fn,
                  mem_req, mem_we, busy, halted};

    always #5 clk = ~clk;

    control_unit #(.RUN_ON_RESET(1'b0)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .fn(fn),
        .alu_lt(alu_lt), .alu_eq(alu_eq), .mem_ack(mem_ack),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .rf_we(rf_we),
        .wb_sel(wb_sel), .alu_op(alu_op), .alu_fn(alu_fn), .mem_req(mem_req),
        .mem_we(mem_we), .busy(busy), .halted(halted)
    );

    task automatic begin_cycle();
        @(negedge clk);
        run     = 1'($urandom);
        opcode  = 3'($urandom);
        fn      = 1'($urandom);
        alu_lt  = 1'($urandom);
        alu_eq  = 1'($urandom);
        mem_ack = 1'($urandom);
    endtask

    task automatic check_out(input string tag, input out_t e);
        #1;
        cyc_cnt++;
        if ((pc_inc || pc_load) && first_strobe == 0) first_strobe = cyc_cnt;
        strobe_cnt += int'(pc_inc) + int'(pc_load);
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    function automatic logic [1:0] model_alu_op(input logic [2:0] op);
        return (op == 3'd3) ? 2'd1 : (op == 3'd4) ? 2'd2 : 2'd0;
    endfunction

    task automatic ensure_fetch();
        if (!next_fetch) begin
            begin_cycle();
            run = 1'b1;
            check_out("idle_wait", '0);
            next_fetch = 1'b1;
        end
    endtask

    // One whole instruction from FETCH to retirement; -1 means "randomize".
    task automatic do_instr(input string tag, input logic [2:0] op, input logic f,
                            input int lt_v, input int eq_v, input int wait_n, input int run_end);
        out_t e;
        bit   is_alu, is_br, is_mem, is_store, take, last;
        int   lat;
        is_alu   = (op == 3'd0) || (op == 3'd3) || (op == 3'd4);
        is_br    = (op == 3'd1) || (op == 3'd5);
        is_store = (op == 3'd6);
        is_mem   = (op == 3'd2) || is_store;
        lat      = is_alu ? 4 : is_mem ? ((is_store ? 4 : 5) + wait_n) : 3;
        ensure_fetch();
        cyc_cnt = 0; strobe_cnt = 0; first_strobe = 0;

        begin_cycle();
        e = '0; e.ir_load = 1'b1; e.busy = 1'b1;
        check_out({tag, "/fetch"}, e);

        begin_cycle();
        opcode = op; fn = f;
        e = '0; e.busy = 1'b1;
        check_out({tag, "/decode"}, e);

        begin_cycle();
        if (lt_v >= 0) alu_lt = 1'(lt_v);
        if (eq_v >= 0) alu_eq = 1'(eq_v);
        e = '0; e.busy = 1'b1;
        if (is_alu) begin
            e.alu_op = model_alu_op(op);
            e.alu_fn = f;
        end else if (is_br) begin
            take      = (op == 3'd1) ? alu_lt : alu_eq;
            e.alu_op  = 2'd3;
            e.alu_fn  = 1'b1;
            e.pc_load = take;
            e.pc_inc  = !take;
        end else if (op == 3'd7) begin
            e.pc_load = f;
            e.pc_inc  = !f;
        end
        last = !(is_alu || is_mem);
        if (last && run_end >= 0) run = 1'(run_end);
        check_out({tag, "/exec"}, e);
        if (last) next_fetch = run;

        if (is_mem) begin
            for (int k = 0; k <= wait_n; k++) begin
                begin_cycle();
                mem_ack = 1'(k == wait_n);
                e = '0; e.busy = 1'b1; e.mem_req = 1'b1; e.mem_we = is_store;
                last = is_store && (k == wait_n);
                e.pc_inc = last;
                if (last && run_end >= 0) run = 1'(run_end);
                check_out({tag, "/mem"}, e);
                if (last) next_fetch = run;
            end
        end

        if (is_alu || (is_mem && !is_store)) begin
            begin_cycle();
            e = '0; e.busy = 1'b1; e.rf_we = 1'b1; e.pc_inc = 1'b1; e.wb_sel = !is_alu;
            if (is_alu) begin
                e.alu_op = model_alu_op(op);
                e.alu_fn = f;
            end
            if (run_end >= 0) run = 1'(run_end);
            check_out({tag, "/wb"}, e);
            next_fetch = run;
        end

        check_int({tag, "/latency"}, first_strobe, lat);
        check_int({tag, "/pc_strobes"}, strobe_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        out_t        e;
        logic [2:0]  rop;
        logic        rfn;

        rst = 1'b1; run = 1'b0; opcode = '0; fn = 1'b0;
        alu_lt = 1'b0; alu_eq = 1'b0; mem_ack = 1'b0;
        next_fetch = 1'b0;
        check_out("reset", '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            begin_cycle();
            run = 1'b0;
            check_out("idle_run0", '0);
        end

        do_instr("addsub",   3'b011, 1'b1, -1, -1, 0, 1);
        do_instr("beq_take", 3'b101, 1'b0, -1,  1, 0, 1);
        do_instr("beq_not",  3'b101, 1'b1, -1,  0, 0, 1);
        do_instr("blt_take", 3'b001, 1'b0,  1, -1, 0, 1);
        do_instr("blt_not",  3'b001, 1'b0,  0, -1, 0, 1);
        do_instr("jmp",      3'b111, 1'b1, -1, -1, 0, 1);
        do_instr("nor",      3'b000, 1'b1, -1, -1, 0, 1);
        do_instr("shift",    3'b100, 1'b0, -1, -1, 0, 1);
        do_instr("load_w3",  3'b010, 1'b0, -1, -1, 3, 1);
        do_instr("store",    3'b110, 1'b0, -1, -1, 0, 1);
        do_instr("store_drop", 3'b110, 1'b0, -1, -1, 2, 0);
        repeat (2) begin
            begin_cycle();
            run = 1'b0;
            check_out("idle_after_drop", '0);
        end

        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom);
            rfn = 1'($urandom);
`ifdef CTRL_HALT_ON_ILLEGAL_EN
            if (rop == 3'b111) rfn = 1'b1;
`endif
            do_instr("rand", rop, rfn, -1, -1, $urandom_range(0, 3), -1);
        end

`ifdef CTRL_HALT_ON_ILLEGAL_EN
        ensure_fetch();
        cyc_cnt = 0; strobe_cnt = 0; first_strobe = 0;
        begin_cycle();
        e = '0; e.ir_load = 1'b1; e.busy = 1'b1;
        check_out("illegal/fetch", e);
        begin_cycle();
        opcode = 3'b111; fn = 1'b0;
        e = '0; e.busy = 1'b1;
        check_out("illegal/decode", e);
        begin_cycle();
        check_out("illegal/exec", e);
        repeat (4) begin
            begin_cycle();
            e = '0; e.halted = 1'b1;
            check_out("illegal/halt", e);
        end
        check_int("illegal/pc_strobes", strobe_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        next_fetch = 1'b0;
`else
        do_instr("illegal_nop", 3'b111, 1'b0, -1, -1, 0, 1);
`endif

        ensure_fetch();
        begin_cycle();
        e = '0; e.ir_load = 1'b1; e.busy = 1'b1;
        check_out("rstmem/fetch", e);
        begin_cycle();
        opcode = 3'b010; fn = 1'b0;
        e = '0; e.busy = 1'b1;
        check_out("rstmem/decode", e);
        begin_cycle();
        check_out("rstmem/exec", e);
        begin_cycle();
        mem_ack = 1'b0;
        e = '0; e.busy = 1'b1; e.mem_req = 1'b1;
        check_out("rstmem/mem", e);
        rst = 1'b1;
        check_out("rstmem/async_drop", '0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        check_out("rstmem/released", '0);
        begin_cycle();
        run = 1'b0;
        check_out("rstmem/idle", '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
